layer_compositor: RTL and testbench

//  Pipelined, parametrised successor to the fixed-priority pixel mux: merges N_LAYERS

---
 rtl/layer_compositor_pkg.sv | 22 ++
 rtl/layer_compositor_if.sv | 29 ++
 rtl/layer_compositor_layer_priority_mux.sv | 23 ++
 rtl/layer_compositor.sv | 126 ++++++++++++
 tb/tb_layer_compositor.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/layer_compositor_pkg.sv
// rtl/layer_compositor_pkg.sv - screen encodings, fade FSM states and shared defaults
package layer_compositor_pkg;

  localparam int CW_DEFAULT = 8;

  localparam logic [1:0] SCR_START = 2'd0;
  localparam logic [1:0] SCR_GAME  = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  // Encoding 3 is unused upstream and aliases the start screen.
  function automatic logic [1:0] map_screen(input logic [1:0] s);
    return (s == 2'd3) ? SCR_START : s;
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - pixel/layer bundle between renderers and the compositor
interface layer_compositor_if #(
  parameter int N_LAYERS = 6,
  parameter int CW       = layer_compositor_pkg::CW_DEFAULT
);
  logic                     de;
  logic                     frame_start;
  logic [N_LAYERS*3*CW-1:0] layer_rgb;
  logic [N_LAYERS-1:0]      layer_a;
  logic [N_LAYERS-1:0]      layer_en;
  logic [3*CW-1:0]          bg_rgb;
  logic [1:0]               screen_state;
  logic [CW-1:0]            R;
  logic [CW-1:0]            G;
  logic [CW-1:0]            B;
  logic                     de_out;
  logic [1:0]               cur_screen;
  logic                     fading;

  modport master (
    output de, frame_start, layer_rgb, layer_a, layer_en, bg_rgb, screen_state,
    input  R, G, B, de_out, cur_screen, fading
  );

  modport slave (
    input  de, frame_start, layer_rgb, layer_a, layer_en, bg_rgb, screen_state,
    output R, G, B, de_out, cur_screen, fading
  );
endinterface

// File: rtl/layer_compositor_layer_priority_mux.sv
// rtl/layer_compositor_layer_priority_mux.sv - picks the highest-priority opaque enabled layer
module layer_priority_mux #(
  parameter int N_LAYERS = 6,
  parameter int CW       = 8
) (
  input  logic [N_LAYERS*3*CW-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]      layer_a,
  input  logic [N_LAYERS-1:0]      layer_en,
  input  logic [3*CW-1:0]          bg_rgb,
  output logic [3*CW-1:0]          rgb
);

  // Walk from lowest to highest priority so layer 0 overwrites last.
  always_comb begin
    rgb = bg_rgb;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_a[i] && layer_en[i]) begin
        rgb = layer_rgb[i*3*CW +: 3*CW];
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - two-stage layer merge with frame-synchronous fade between screens
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int N_LAYERS   = 6,
  parameter int CW         = CW_DEFAULT,
  parameter int FADE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  layer_compositor_if.slave  bus
);

  localparam int              LW        = FADE_SHIFT + 1;
  localparam int              PW        = CW + FADE_SHIFT + 1;
  localparam logic [LW-1:0]   LEVEL_MAX = LW'(1 << FADE_SHIFT);

  fade_state_t     state;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_dn;
  logic [LW-1:0]   level_up;
  logic [1:0]      target;
  logic [1:0]      cur_screen;
  logic            fading;

  logic [3*CW-1:0] mux_rgb;
  logic [3*CW-1:0] s1_rgb;
  logic            s1_de;
  logic [CW-1:0]   r_q, g_q, b_q;
  logic            de_q;

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [LW-1:0] lv);
    logic [PW-1:0] p;
    p = PW'(c) * PW'(lv);
    return CW'(p >> FADE_SHIFT);
  endfunction

  layer_priority_mux #(.N_LAYERS(N_LAYERS), .CW(CW)) u_mux (
    .layer_rgb (bus.layer_rgb),
    .layer_a   (bus.layer_a),
    .layer_en  (bus.layer_en),
    .bg_rgb    (bus.bg_rgb),
    .rgb       (mux_rgb)
  );

  assign level_dn = (level == '0) ? '0 : level - LW'(1);
  assign level_up = (level == LEVEL_MAX) ? LEVEL_MAX : level + LW'(1);

  // Level only moves on frame_start so every pixel of a frame shares one brightness.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      level      <= LEVEL_MAX;
      target     <= SCR_START;
      cur_screen <= SCR_START;
      fading     <= 1'b0;
    end else begin
      target <= map_screen(bus.screen_state);
      if (bus.frame_start) begin
        unique case (state)
          IDLE: begin
            if (target != cur_screen) begin
              state  <= FADE_OUT;
              level  <= level_dn;
              fading <= 1'b1;
            end
          end
          FADE_OUT: begin
            level <= level_dn;
            if (level_dn == '0) state <= SWAP;
          end
          SWAP: begin
            cur_screen <= target;
            level      <= LW'(1);
            state      <= FADE_IN;
          end
          FADE_IN: begin
            if (target != cur_screen) begin
              level <= level_dn;
              state <= (level_dn == '0) ? SWAP : FADE_OUT;
            end else begin
              level <= level_up;
              if (level_up == LEVEL_MAX) begin
                state  <= IDLE;
                fading <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_rgb <= '0;
      s1_de  <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      de_q   <= 1'b0;
    end else begin
      s1_rgb <= mux_rgb;
      s1_de  <= bus.de;
      de_q   <= s1_de;
      if (s1_de) begin
        r_q <= scale(s1_rgb[3*CW-1:2*CW], level);
        g_q <= scale(s1_rgb[2*CW-1:CW],   level);
        b_q <= scale(s1_rgb[CW-1:0],      level);
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign bus.R          = r_q;
  assign bus.G          = g_q;
  assign bus.B          = b_q;
  assign bus.de_out     = de_q;
  assign bus.cur_screen = cur_screen;
  assign bus.fading     = fading;

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - self-checking bench for layer_compositor
module tb_layer_compositor;
  localparam int N    = 6;
  localparam int CW   = 8;
  localparam int FS   = 4;
  localparam int LMAX = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  layer_compositor_if #(.N_LAYERS(N), .CW(CW)) bus();

  layer_compositor #(.N_LAYERS(N), .CW(CW), .FADE_SHIFT(FS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ref_pixel(input logic [N*24-1:0] rgb, input logic [N-1:0] a,
                                            input logic [N-1:0] en, input logic [23:0] bg,
                                            input logic de, input int lvl);
    logic [23:0] c;
    logic [23:0] o;
    c = bg;
    if (!de) return 24'h0;
    for (int i = 0; i < N; i++) begin
      if (a[i] && en[i]) begin
        c = rgb[i*24 +: 24];
        break;
      end
    end
    for (int k = 0; k < 3; k++) o[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * lvl) / LMAX);
    return o;
  endfunction

  function automatic logic [23:0] grey_at(input int lvl);
    logic [7:0] v;
    v = 8'((128 * lvl) / LMAX);
    return {v, v, v};
  endfunction

  function automatic logic [N*24-1:0] rand_layers();
    logic [N*24-1:0] r;
    for (int i = 0; i < N; i++) r[i*24 +: 24] = 24'($urandom);
    return r;
  endfunction

  function automatic logic [23:0] out_rgb();
    return {bus.R, bus.G, bus.B};
  endfunction

  task automatic drive_random;
    bus.de        = 1'($urandom);
    bus.layer_rgb = rand_layers();
    bus.layer_a   = N'($urandom);
    bus.layer_en  = N'($urandom);
    bus.bg_rgb    = 24'($urandom);
  endtask

  task automatic set_grey_layer;
    bus.layer_rgb           = rand_layers();
    bus.layer_rgb[23:0]     = 24'h808080;
    bus.layer_a             = '1;
    bus.layer_en            = '1;
    bus.de                  = 1'b1;
  endtask

  task automatic do_frame;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      drive_random();
      bus.frame_start  = 1'($urandom);
      bus.screen_state = 2'($urandom);
      tick();
    end
    checks++; if (out_rgb() !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected %h", out_rgb(), 24'h0); end
    checks++; if (bus.de_out !== 1'b0) begin errors++; $display("FAIL reset_de_out: got %b expected 0", bus.de_out); end
    checks++; if (bus.cur_screen !== 2'd0) begin errors++; $display("FAIL reset_cur_screen: got %0d expected 0", bus.cur_screen); end
    checks++; if (bus.fading !== 1'b0) begin errors++; $display("FAIL reset_fading: got %b expected 0", bus.fading); end
    bus.frame_start  = 1'b0;
    bus.screen_state = 2'd0;
    bus.de           = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_priority;
    bus.layer_rgb          = rand_layers();
    bus.layer_rgb[24 +: 24] = 24'hFF0000;
    bus.layer_rgb[72 +: 24] = 24'h00FF00;
    bus.bg_rgb             = 24'h123456;
    bus.layer_a            = 6'b001010;
    bus.layer_en           = 6'b111111;
    bus.de                 = 1'b1;
    repeat (2) tick();
    checks++; if (out_rgb() !== 24'hFF0000) begin errors++; $display("FAIL prio_layer1: got %h expected %h", out_rgb(), 24'hFF0000); end
    bus.layer_en = 6'b111101;
    repeat (2) tick();
    checks++; if (out_rgb() !== 24'h00FF00) begin errors++; $display("FAIL prio_layer3: got %h expected %h", out_rgb(), 24'h00FF00); end
    bus.layer_a = 6'b000000;
    repeat (2) tick();
    checks++; if (out_rgb() !== 24'h123456) begin errors++; $display("FAIL prio_bg: got %h expected %h", out_rgb(), 24'h123456); end
  endtask

  task automatic test_random_pixels;
    logic [23:0] exp_q[$];
    logic        de_q[$];
    logic [23:0] e;
    logic        d;
    for (int i = 0; i < 200; i++) begin
      drive_random();
      bus.screen_state = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      exp_q.push_back(ref_pixel(bus.layer_rgb, bus.layer_a, bus.layer_en, bus.bg_rgb, bus.de, LMAX));
      de_q.push_back(bus.de);
      tick();
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        d = de_q.pop_front();
        checks++; if (out_rgb() !== e) begin errors++; $display("FAIL rand_rgb[%0d]: got %h expected %h", i, out_rgb(), e); end
        checks++; if (bus.de_out !== d) begin errors++; $display("FAIL rand_de_out[%0d]: got %b expected %b", i, bus.de_out, d); end
      end
    end
  endtask

  task automatic test_blanking;
    bus.layer_rgb[23:0] = 24'hFFFFFF;
    bus.layer_a  = 6'b000001;
    bus.layer_en = 6'b000001;
    bus.de       = 1'b0;
    repeat (2) tick();
    checks++; if (out_rgb() !== 24'h0) begin errors++; $display("FAIL blank_rgb: got %h expected %h", out_rgb(), 24'h0); end
    checks++; if (bus.de_out !== 1'b0) begin errors++; $display("FAIL blank_de_out: got %b expected 0", bus.de_out); end
  endtask

  task automatic test_fade;
    int lvl;
    logic [1:0] ecur;
    set_grey_layer();
    bus.screen_state = 2'd1;
    repeat (2) tick();
    for (int k = 1; k <= 32; k++) begin
      do_frame();
      lvl  = (k <= 16) ? 16 - k : k - 16;
      ecur = (k <= 16) ? 2'd0 : 2'd1;
      checks++; if (out_rgb() !== grey_at(lvl)) begin errors++; $display("FAIL fade_rgb[%0d]: got %h expected %h", k, out_rgb(), grey_at(lvl)); end
      checks++; if (bus.cur_screen !== ecur) begin errors++; $display("FAIL fade_cur[%0d]: got %0d expected %0d", k, bus.cur_screen, ecur); end
      checks++; if (bus.fading !== (k < 32)) begin errors++; $display("FAIL fade_fading[%0d]: got %b expected %b", k, bus.fading, (k < 32)); end
    end
  endtask

  task automatic test_reversal;
    int lvl;
    logic [1:0] ecur;
    bus.screen_state = 2'd3;
    repeat (2) tick();
    for (int k = 1; k <= 21; k++) begin
      do_frame();
      lvl  = (k <= 16) ? 16 - k : k - 16;
      ecur = (k <= 16) ? 2'd1 : 2'd0;
      checks++; if (out_rgb() !== grey_at(lvl)) begin errors++; $display("FAIL rev_down_rgb[%0d]: got %h expected %h", k, out_rgb(), grey_at(lvl)); end
      checks++; if (bus.cur_screen !== ecur) begin errors++; $display("FAIL rev_down_cur[%0d]: got %0d expected %0d", k, bus.cur_screen, ecur); end
    end
    bus.screen_state = 2'd1;
    tick();
    for (int j = 1; j <= 6; j++) begin
      do_frame();
      lvl  = (j <= 5) ? 5 - j : 1;
      ecur = (j <= 5) ? 2'd0 : 2'd1;
      checks++; if (out_rgb() !== grey_at(lvl)) begin errors++; $display("FAIL rev_rgb[%0d]: got %h expected %h", j, out_rgb(), grey_at(lvl)); end
      checks++; if (bus.cur_screen !== ecur) begin errors++; $display("FAIL rev_cur[%0d]: got %0d expected %0d", j, bus.cur_screen, ecur); end
      checks++; if (bus.fading !== 1'b1) begin errors++; $display("FAIL rev_fading[%0d]: got %b expected 1", j, bus.fading); end
    end
  endtask

  task automatic test_midfade_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_grey_layer();
    bus.screen_state = 2'd1;
    repeat (2) tick();
    for (int k = 1; k <= 9; k++) do_frame();
    checks++; if (out_rgb() !== grey_at(7)) begin errors++; $display("FAIL mid_level7: got %h expected %h", out_rgb(), grey_at(7)); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_rgb() !== 24'h0) begin errors++; $display("FAIL mid_rst_rgb: got %h expected %h", out_rgb(), 24'h0); end
    checks++; if (bus.fading !== 1'b0) begin errors++; $display("FAIL mid_rst_fading: got %b expected 0", bus.fading); end
    checks++; if (bus.cur_screen !== 2'd0) begin errors++; $display("FAIL mid_rst_cur: got %0d expected 0", bus.cur_screen); end
    rst_n = 1'b1;
    bus.screen_state = 2'd0;
    repeat (3) tick();
    checks++; if (out_rgb() !== grey_at(16)) begin errors++; $display("FAIL mid_post_level: got %h expected %h", out_rgb(), grey_at(16)); end
    checks++; if (bus.fading !== 1'b0) begin errors++; $display("FAIL mid_post_fading: got %b expected 0", bus.fading); end
    checks++; if (bus.de_out !== 1'b1) begin errors++; $display("FAIL mid_post_de_out: got %b expected 1", bus.de_out); end
  endtask

  initial begin
    bus.de           = 1'b0;
    bus.frame_start  = 1'b0;
    bus.layer_rgb    = '0;
    bus.layer_a      = '0;
    bus.layer_en     = '0;
    bus.bg_rgb       = '0;
    bus.screen_state = 2'd0;
    test_reset();
    test_priority();
    test_random_pixels();
    test_blanking();
    test_fade();
    test_reversal();
    test_midfade_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
